alu_result_collector: RTL and testbench

- Downstream consumer of the 8-bit ALU's result/interrupt outputs.
- When the ALU raises alu_irq, the block captures alu_out into a first-word-fall-through FIFO and drives the alu_irq_clr handshake back to the ALU.
- Results are presented to the host/scoreboard side through a valid/ready read port.
- Sits between the ALU and the result-consuming logic, decoupling ALU completion timing from consumer back-pressure.

---
 rtl/alu_result_collector.sv | 169 ++++++++++++++++
 tb/tb_alu_result_collector.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_collector.sv
// alu_result_collector
// Captures ALU results on alu_irq into a first-word-fall-through FIFO,
// acknowledges the ALU with a registered alu_irq_clr, and presents the
// results to the consumer through a valid/ready read port.
// Optional build macro: ALU_RESULT_PARITY_EN adds an even-parity bit per
// entry and the rd_parity output.
module alu_result_collector #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_irq,
  output logic              alu_irq_clr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
`ifdef ALU_RESULT_PARITY_EN
  output logic              rd_parity,
`endif
  output logic [CW-1:0]     count,
  output logic              overflow,
  input  logic              ovf_clr
);

`ifdef ALU_RESULT_PARITY_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  typedef enum logic {IDLE, ACK} state_t;

  state_t              state_reg;
  state_t              state_next;
  logic                alu_irq_clr_reg;
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       count_next;
  logic                overflow_reg;
  logic [ENTRY_W-1:0]  mem_reg [DEPTH];
  logic [ENTRY_W-1:0]  hold_reg;
  logic [ENTRY_W-1:0]  wr_entry;
  logic [ENTRY_W-1:0]  head_entry;
  logic [ENTRY_W-1:0]  out_entry;
  logic [DEPTH-1:0]    wr_en;
  logic                push_req;
  logic                push_ok;
  logic                drop;
  logic                pop;
  logic                not_full;

  // Entry formatting: data, plus even parity of the captured result when enabled.
`ifdef ALU_RESULT_PARITY_EN
  assign wr_entry = {^alu_out, alu_out};
`else
  assign wr_entry = alu_out;
`endif

  assign rd_valid = (count_reg != '0);
  assign pop      = rd_valid && rd_ready;
  assign not_full = (count_reg < CW'(DEPTH));
  // A full FIFO can still take a result when the head leaves on the same edge.
  assign push_ok  = push_req && (not_full || pop);
  assign drop     = push_req && !push_ok;

  // Next-state logic: one capture per irq assertion, then wait for irq to fall.
  always_comb begin
    state_next = state_reg;
    push_req   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (alu_irq) begin
          push_req   = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!alu_irq) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy update for push-only, pop-only or simultaneous push+pop.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // FSM state and the acknowledge, which is high exactly while in ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      alu_irq_clr_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      alu_irq_clr_reg <= (state_next == ACK);
    end
  end

  // Pointers, occupancy and the sticky overflow flag (a drop beats a clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Per-entry write enables decoded from the write pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_ok && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  // Storage array; cleared on reset so unwritten entries never read as X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= wr_entry;
      end
    end
  end

  // Remember the entry that was last popped so the read port holds it when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= '0;
    end else if (pop) begin
      hold_reg <= head_entry;
    end
  end

  assign head_entry = mem_reg[rd_ptr_reg];
  assign out_entry  = rd_valid ? head_entry : hold_reg;

  assign rd_data     = out_entry[DATA_W-1:0];
`ifdef ALU_RESULT_PARITY_EN
  assign rd_parity   = out_entry[DATA_W];
`endif
  assign alu_irq_clr = alu_irq_clr_reg;
  assign count       = count_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_alu_result_collector;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] alu_out;
  logic              alu_irq;
  logic              alu_irq_clr;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
`ifdef ALU_RESULT_PARITY_EN
  logic              rd_parity;
`endif
  logic [CW-1:0]     count;
  logic              overflow;
  logic              ovf_clr;

  int checks = 0;
  int errors = 0;

  // Reference model: stored results in arrival order, plus protocol flags.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_last;
  bit                m_waiting;
  bit                m_ovf;
  bit                verbose;

  alu_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_out    (alu_out),
    .alu_irq    (alu_irq),
    .alu_irq_clr(alu_irq_clr),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
`ifdef ALU_RESULT_PARITY_EN
    .rd_parity  (rd_parity),
`endif
    .count      (count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last    = '0;
    m_waiting = 1'b0;
    m_ovf     = 1'b0;
  endtask

  task automatic check_outputs();
    logic [DATA_W-1:0] exp_data;
    exp_data = (m_q.size() != 0) ? m_q[0] : m_last;
    check_val("irq_clr",  alu_irq_clr, m_waiting);
    check_val("rd_valid", rd_valid, m_q.size() != 0);
    check_val("count",    count, m_q.size());
    check_val("overflow", overflow, m_ovf);
    check_val("rd_data",  rd_data, exp_data);
`ifdef ALU_RESULT_PARITY_EN
    check_val("rd_parity", rd_parity, ^exp_data);
`endif
  endtask

  // One clock: evaluate the model on pre-edge inputs, clock the DUT, compare.
  task automatic tick();
    bit                pop, push_req, push_ok, irq_s, clr_s;
    logic [DATA_W-1:0] data_s;
    irq_s    = alu_irq;
    clr_s    = ovf_clr;
    data_s   = alu_out;
    pop      = (m_q.size() != 0) && rd_ready;
    push_req = !m_waiting && irq_s;
    push_ok  = push_req && ((m_q.size() < DEPTH) || pop);
    @(posedge clk);
    if (pop) begin
      m_last = m_q.pop_front();
      if (verbose) $display("pop  %02h", m_last);
    end
    if (push_ok) begin
      m_q.push_back(data_s);
      if (verbose) $display("push %02h (count %0d)", data_s, m_q.size());
    end
    if (push_req && !push_ok) begin
      m_ovf = 1'b1;
      if (verbose) $display("drop %02h", data_s);
    end else if (clr_s) begin
      m_ovf = 1'b0;
    end
    if (push_req) m_waiting = 1'b1;
    else if (m_waiting && !irq_s) m_waiting = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic capture(input logic [DATA_W-1:0] d, input bit rdy);
    alu_out  = d;
    alu_irq  = 1'b1;
    rd_ready = rdy;
    tick();
    alu_irq  = 1'b0;
    tick();
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    alu_out  = '0;
    alu_irq  = 1'b0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;
    verbose  = 1'b1;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_irq_clr", alu_irq_clr, 0);
    check_val("rst_valid",   rd_valid, 0);
    check_val("rst_count",   count, 0);
    check_val("rst_ovf",     overflow, 0);
    check_val("rst_data",    rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single capture with irq held for three cycles.
    $display("-- single capture");
    alu_out = 8'hA5;
    alu_irq = 1'b1;
    tick();
    check_val("single_count", count, 1);
    check_val("single_data",  rd_data, 8'hA5);
    tick();
    check_val("single_clr",   alu_irq_clr, 1);
    tick();
    alu_irq = 1'b0;
    tick();
    check_val("single_clr_off", alu_irq_clr, 0);
    check_val("single_one",     count, 1);
    drain();

    // Ordering across pointer wrap.
    $display("-- ordering and wrap");
    for (int i = 1; i <= 10; i++) capture(8'(i), 1'b1);
    tick();
    check_val("wrap_last", rd_data, 8'h0A);

    // Fill, overflow, drain, clear.
    $display("-- full and overflow");
    for (int i = 0; i < DEPTH; i++) capture(8'h10 + 8'(i), 1'b0);
    check_val("full_count", count, DEPTH);
    capture(8'hFF, 1'b0);
    check_val("ovf_set",   overflow, 1);
    check_val("ovf_count", count, DEPTH);
    drain();
    check_val("ovf_no_ff", rd_data, 8'h17);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_val("ovf_clr", overflow, 0);

    // Full with a simultaneous pop.
    $display("-- full with simultaneous pop");
    for (int i = 0; i < DEPTH; i++) capture(8'h20 + 8'(i), 1'b0);
    alu_out  = 8'h55;
    alu_irq  = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    alu_irq  = 1'b0;
    check_val("fpop_count", count, DEPTH);
    check_val("fpop_ovf",   overflow, 0);
    tick();
    drain();
    check_val("fpop_last",  rd_data, 8'h55);

`ifdef ALU_RESULT_PARITY_EN
    $display("-- parity");
    capture(8'h07, 1'b0);
    capture(8'h03, 1'b0);
    check_val("par_07", rd_parity, 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_val("par_03", rd_parity, 0);
    drain();
`endif

    // Asynchronous reset while in ACK.
    $display("-- reset during ACK");
    alu_out = 8'h3C;
    alu_irq = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_clr",   alu_irq_clr, 0);
    check_val("arst_count", count, 0);
    check_val("arst_valid", rd_valid, 0);
    model_reset();
    alu_irq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized traffic, alternating between back-pressure and free-flowing reads.
    $display("-- random traffic");
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      alu_out  = 8'($urandom);
      alu_irq  = ($urandom_range(0, 2) != 0);
      rd_ready = ((i / 300) % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
